ilim_dac_scheduler: RTL and testbench
=====================================

Name: ilim_dac_scheduler

Overview:
- Sequences updates of all 8 ILIM DAC channels through the existing single-channel AD8803 serializer, using its trig/done handshake.
- Software writes per-channel shadow values over OPB. The block tracks which channels are dirty and serves them round-robin, one serial transfer at a time.
- Sits between the OPB slave decode and the serializer's trig/data/address inputs; the serializer's OPB writes to those registers are no longer used.

Parameters:
- NUM_CH, 8, number of DAC channels (fixed by the AD8803 3-bit address; legal range 1..8)
- DONE_TIMEOUT, 16'd4096, OPB_CLK cycles to wait for each done edge before aborting the transfer
- REFRESH_PERIOD, 24'd3200000, OPB_CLK cycles between automatic full refreshes (only when AUTO_REFRESH_EN is defined)

Ports:
- OPB_CLK  in  1  32 MHz system bus clock; all logic on its rising edge
- OPB_RST_N  in  1  asynchronous, active-low reset
- OPB_ADDR  in  4  register address
- OPB_DI  in  16  write data
- OPB_WE  in  1  write strobe, one cycle
- OPB_RE  in  1  read enable
- OPB_DO  out  32  read data; 0 when OPB_RE is low or the address is unmapped
- DAC_TRIG  out  1  to serializer trig
- DAC_DATA  out  8  to serializer data
- DAC_ADDR  out  3  to serializer address
- DAC_DONE  in  1  from serializer done (tx_clk domain, asynchronous to OPB_CLK)
- SCHED_BUSY  out  1  high while a transfer is in progress
- SCHED_ERR  out  1  sticky timeout flag

Behaviour:
- Reset values: DAC_TRIG=0, DAC_DATA=0, DAC_ADDR=0, SCHED_BUSY=0, SCHED_ERR=0. All shadow registers 0, dirty mask 0, enable 0, round-robin pointer 0, FSM in IDLE.
- Register map:
  - 0x0–0x7: channel shadow values (8 bits each). A write stores OPB_DI[7:0] and sets that channel's dirty bit.
  - 0x8: CTRL. Bit 0 = enable (R/W). Bit 1 = update_all (write-1 pulse; sets all dirty bits; reads 0).
  - 0x9: STATUS (read). Bit 0 = busy, bit 1 = err, bits 15:8 = dirty mask, bits 18:16 = current channel. Writing a 1 to bit 1 clears err.
  - 0xA: TIMEOUT_CNT (read-only, 16 bits). Counts timeouts, saturates at 0xFFFF.
- DAC_DONE is passed through a 2-flop synchronizer; all FSM references below use the synchronized done_s.
- FSM states and transitions:
  - IDLE: if enable=1 and dirty≠0, pick the first dirty channel at or after the pointer (wrapping 7→0) and go to LOAD.
  - LOAD (1 cycle): drive DAC_ADDR=ch and DAC_DATA=shadow[ch], clear dirty[ch], set busy. Go to TRIG.
  - TRIG: hold DAC_TRIG=1 until done_s=1, then go to RELEASE.
  - RELEASE: drive DAC_TRIG=0 until done_s=0. Then set pointer=ch+1 (wrapping), clear busy, return to IDLE.
- DAC_DATA and DAC_ADDR are held stable from LOAD until the FSM leaves RELEASE.
- Timeout: the wait in TRIG and the wait in RELEASE each have a DONE_TIMEOUT counter. On expiry:
  - set SCHED_ERR and increment TIMEOUT_CNT;
  - re-set dirty[ch] so the channel is retried;
  - drop DAC_TRIG, go to a DRAIN state, and wait for done_s=0 before returning to IDLE.
- Simultaneous events:
  - An OPB write to channel ch in the same cycle as LOAD clears dirty[ch]: the set wins, so dirty[ch] stays 1.
  - The new value is sent in a later transfer; the transfer in flight uses the value latched in LOAD.
- Clearing enable mid-transfer: the current transfer completes; no new transfer starts.
- Minimum spacing between transfers: 1 idle cycle.
- Reset mid-transfer: all outputs return to reset values immediately. The serializer sees trig fall and self-clears.

Optional Feature:
- Macro ILIM_DAC_AUTO_REFRESH_EN.
- When defined: a free-running counter of REFRESH_PERIOD cycles, active while enable=1. On wrap it sets all dirty bits, re-writing every channel to recover from upsets. Counter resets to 0 whenever enable=0.
- When undefined: no counter; channels are sent only after software writes or update_all.

Test Plan:
- Write ch3=0x5A, enable=1; serializer model asserts done 40 cycles after trig → DAC_ADDR=3, DAC_DATA=0x5A, exactly one trig pulse, dirty=0x00, busy back to 0.
- Write ch0, ch7 and ch2 with pointer=0, then enable → transfer order 0, 2, 7; final pointer=0.
- Rewrite ch5 (0x11→0x22) while ch5 is in TRIG → first transfer sends 0x11, second sends 0x22, dirty=0 at end.
- Serializer model never asserts done, DONE_TIMEOUT=16 → trig drops after 16 cycles, err=1, TIMEOUT_CNT=1, dirty[ch] still set; write-1 to STATUS bit 1 clears err.
- Assert OPB_RST_N low while in TRIG → DAC_TRIG=0 in the same cycle, registers read 0 after release, no transfer starts until enable is rewritten.
- With ILIM_DAC_AUTO_REFRESH_EN, REFRESH_PERIOD=1000 → 8 transfers (ch0..7) start after cycle 1000; without the macro, no transfers occur.

Source files
------------

// File: rtl/ilim_dac_scheduler_if.sv
// OPB register-bus bundle for the ILIM DAC scheduler.
// The master drives address, write data and strobes; the slave returns read data.
interface ilim_dac_scheduler_if;
  logic [3:0]  OPB_ADDR;
  logic [15:0] OPB_DI;
  logic        OPB_WE;
  logic        OPB_RE;
  logic [31:0] OPB_DO;

  modport master (
    output OPB_ADDR,
    output OPB_DI,
    output OPB_WE,
    output OPB_RE,
    input  OPB_DO
  );

  modport slave (
    input  OPB_ADDR,
    input  OPB_DI,
    input  OPB_WE,
    input  OPB_RE,
    output OPB_DO
  );
endinterface

// File: rtl/ilim_dac_scheduler.sv
// ILIM DAC update scheduler.
// Holds per-channel shadow values written over OPB, tracks dirty channels and
// feeds them round-robin to the single-channel AD8803 serializer through its
// trig/done handshake. DAC_DONE comes from the serializer clock domain and is
// resynchronised before use. A per-wait timeout aborts a stuck transfer,
// re-marks the channel dirty and raises a sticky error.
// Optional build macro ILIM_DAC_AUTO_REFRESH_EN adds a periodic full refresh.
module ilim_dac_scheduler #(
  parameter int unsigned  NUM_CH         = 8,
  parameter logic [15:0]  DONE_TIMEOUT   = 16'd4096,
  parameter logic [23:0]  REFRESH_PERIOD = 24'd3200000
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST_N,
  ilim_dac_scheduler_if.slave   opb,
  output logic                  DAC_TRIG,
  output logic [7:0]            DAC_DATA,
  output logic [2:0]            DAC_ADDR,
  input  logic                  DAC_DONE,
  output logic                  SCHED_BUSY,
  output logic                  SCHED_ERR
);

  localparam int         NCH     = int'(NUM_CH);
  localparam logic [7:0] CH_MASK = 8'((16'd1 << NUM_CH) - 16'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_RELEASE,
    S_DRAIN
  } state_t;

  // Register file
  logic [7:0]  r_shadow [8];
  logic [7:0]  r_dirty;
  logic        r_enable;
  logic        r_err;
  logic [15:0] r_tmo_cnt;

  // Done synchroniser
  logic        r_done_m;
  logic        r_done_s;

  // FSM state and registered outputs
  state_t      r_state;
  logic [2:0]  r_ch;
  logic [2:0]  r_ptr;
  logic [15:0] r_wait;
  logic        r_trig;
  logic [7:0]  r_dac_data;
  logic [2:0]  r_dac_addr;
  logic        r_busy;

  // Combinational helpers
  logic        w_wr_ch;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_load;
  logic        w_wait_hit;
  logic        w_timeout;
  logic        w_refresh;
  logic [7:0]  w_dirty_nxt;
  logic [2:0]  w_next_ch;
  logic [2:0]  w_ptr_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wr_ch   = opb.OPB_WE && (opb.OPB_ADDR < 4'(NCH));
  assign w_wr_ctrl = opb.OPB_WE && (opb.OPB_ADDR == 4'h8);
  assign w_wr_stat = opb.OPB_WE && (opb.OPB_ADDR == 4'h9);

  assign w_load     = (r_state == S_LOAD);
  assign w_wait_hit = (r_wait == DONE_TIMEOUT - 16'd1);
  // Expiry while waiting for done to rise (TRIG) or to fall (RELEASE)
  assign w_timeout  = ((r_state == S_TRIG)    && !r_done_s && w_wait_hit) ||
                      ((r_state == S_RELEASE) &&  r_done_s && w_wait_hit);

  assign w_ptr_nxt = (r_ch == 3'(NCH - 1)) ? 3'd0 : r_ch + 3'd1;

  // Two-flop synchroniser for the serializer done flag
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_done_m <= 1'b0;
      r_done_s <= 1'b0;
    end else begin
      r_done_m <= DAC_DONE;
      r_done_s <= r_done_m;
    end
  end

`ifdef ILIM_DAC_AUTO_REFRESH_EN
  logic [23:0] r_refresh_cnt;

  // Free-running refresh timer, held at zero while the scheduler is disabled
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_refresh_cnt <= 24'd0;
    end else if (!r_enable) begin
      r_refresh_cnt <= 24'd0;
    end else if (r_refresh_cnt == REFRESH_PERIOD - 24'd1) begin
      r_refresh_cnt <= 24'd0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 24'd1;
    end
  end

  assign w_refresh = r_enable && (r_refresh_cnt == REFRESH_PERIOD - 24'd1);
  assign w_unused  = ^opb.OPB_DI[15:8];
`else
  assign w_refresh = 1'b0;
  assign w_unused  = ^{opb.OPB_DI[15:8], REFRESH_PERIOD};
`endif

  // Next dirty mask: LOAD clears, then every set source overrides the clear
  always_comb begin
    w_dirty_nxt = r_dirty;
    if (w_load) begin
      w_dirty_nxt[r_ch] = 1'b0;
    end
    if (w_timeout) begin
      w_dirty_nxt[r_ch] = 1'b1;
    end
    if ((w_wr_ctrl && opb.OPB_DI[1]) || w_refresh) begin
      w_dirty_nxt = w_dirty_nxt | CH_MASK;
    end
    if (w_wr_ch) begin
      w_dirty_nxt[opb.OPB_ADDR[2:0]] = 1'b1;
    end
    w_dirty_nxt = w_dirty_nxt & CH_MASK;
  end

  // Round-robin pick: first dirty channel at or after the pointer, wrapping
  always_comb begin
    logic       found;
    logic [2:0] idx;
    found     = 1'b0;
    idx       = 3'd0;
    w_next_ch = r_ptr;
    for (int i = 0; i < NCH; i++) begin
      idx = 3'((int'(r_ptr) + i) % NCH);
      if (!found && r_dirty[idx]) begin
        found     = 1'b1;
        w_next_ch = idx;
      end
    end
  end

  // Software-visible registers: shadows, dirty mask, enable, error and timeout count
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 8'd0;
      end
      r_dirty   <= 8'd0;
      r_enable  <= 1'b0;
      r_err     <= 1'b0;
      r_tmo_cnt <= 16'd0;
    end else begin
      if (w_wr_ch) begin
        r_shadow[opb.OPB_ADDR[2:0]] <= opb.OPB_DI[7:0];
      end
      if (w_wr_ctrl) begin
        r_enable <= opb.OPB_DI[0];
      end
      r_dirty <= w_dirty_nxt;
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_wr_stat && opb.OPB_DI[1]) begin
        r_err <= 1'b0;
      end
      if (w_timeout && (r_tmo_cnt != 16'hFFFF)) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end
  end

  // Transfer sequencer: IDLE -> LOAD -> TRIG -> RELEASE, with DRAIN after a timeout
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      r_state    <= S_IDLE;
      r_ch       <= 3'd0;
      r_ptr      <= 3'd0;
      r_wait     <= 16'd0;
      r_trig     <= 1'b0;
      r_dac_data <= 8'd0;
      r_dac_addr <= 3'd0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_enable && (r_dirty != 8'd0)) begin
            r_ch    <= w_next_ch;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_dac_addr <= r_ch;
          r_dac_data <= r_shadow[r_ch];
          r_busy     <= 1'b1;
          r_trig     <= 1'b1;
          r_wait     <= 16'd0;
          r_state    <= S_TRIG;
        end
        S_TRIG: begin
          if (r_done_s) begin
            r_trig  <= 1'b0;
            r_wait  <= 16'd0;
            r_state <= S_RELEASE;
          end else if (w_wait_hit) begin
            r_trig  <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        S_RELEASE: begin
          if (!r_done_s) begin
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_wait_hit) begin
            r_state <= S_DRAIN;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        S_DRAIN: begin
          if (!r_done_s) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // OPB read mux; zero when not reading or unmapped
  always_comb begin
    w_rdata = 32'd0;
    if (opb.OPB_RE) begin
      if (opb.OPB_ADDR < 4'(NCH)) begin
        w_rdata = {24'd0, r_shadow[opb.OPB_ADDR[2:0]]};
      end else begin
        case (opb.OPB_ADDR)
          4'h8:    w_rdata = {31'd0, r_enable};
          4'h9:    w_rdata = {13'd0, r_ch, r_dirty, 6'd0, r_err, r_busy};
          4'hA:    w_rdata = {16'd0, r_tmo_cnt};
          default: w_rdata = 32'd0;
        endcase
      end
    end
  end

  assign opb.OPB_DO = w_rdata;
  assign DAC_TRIG   = r_trig;
  assign DAC_DATA   = r_dac_data;
  assign DAC_ADDR   = r_dac_addr;
  assign SCHED_BUSY = r_busy;
  assign SCHED_ERR  = r_err;

endmodule

// File: tb/tb_ilim_dac_scheduler.sv
// Directed bench for ilim_dac_scheduler.
// dut_a talks to a serializer model that raises done 40 cycles after trig;
// dut_b (DONE_TIMEOUT=16) talks to a serializer that never answers.
module tb_ilim_dac_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ilim_dac_scheduler_if ifa ();
  ilim_dac_scheduler_if ifb ();

  logic       trig_a, busy_a, err_a, trig_b, busy_b, err_b;
  logic [7:0] data_a, data_b;
  logic [2:0] addr_a, addr_b;
  logic       done_a = 1'b0;
  logic       done_b;
  assign done_b = 1'b0;

  ilim_dac_scheduler #(.NUM_CH(8), .DONE_TIMEOUT(16'd4096), .REFRESH_PERIOD(24'd1000)) dut_a (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .opb(ifa),
    .DAC_TRIG(trig_a), .DAC_DATA(data_a), .DAC_ADDR(addr_a), .DAC_DONE(done_a),
    .SCHED_BUSY(busy_a), .SCHED_ERR(err_a));

  ilim_dac_scheduler #(.NUM_CH(8), .DONE_TIMEOUT(16'd16), .REFRESH_PERIOD(24'd1000)) dut_b (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .opb(ifb),
    .DAC_TRIG(trig_b), .DAC_DATA(data_b), .DAC_ADDR(addr_b), .DAC_DONE(done_b),
    .SCHED_BUSY(busy_b), .SCHED_ERR(err_b));

  int checks = 0;
  int errors = 0;

  // Serializer model and trig monitors
  logic [10:0] log_a [$];
  int   dly_a   = 0;
  logic ta_prev = 1'b0;
  logic tb_prev = 1'b0;
  int   rise_b  = 0;
  int   hi_b    = 0;

  always @(negedge clk) begin
    if (trig_a && !ta_prev) log_a.push_back({addr_a, data_a});
    ta_prev = trig_a;
    if (trig_a) begin
      if (dly_a >= 40) done_a = 1'b1;
      else dly_a = dly_a + 1;
    end else begin
      dly_a  = 0;
      done_a = 1'b0;
    end
    if (trig_b && !tb_prev) begin
      rise_b = rise_b + 1;
      hi_b   = 1;
    end else if (trig_b) begin
      hi_b = hi_b + 1;
    end
    tb_prev = trig_b;
  end

  task automatic opb_wr(input bit b, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    if (b) begin ifb.OPB_ADDR = a; ifb.OPB_DI = d; ifb.OPB_WE = 1'b1; end
    else   begin ifa.OPB_ADDR = a; ifa.OPB_DI = d; ifa.OPB_WE = 1'b1; end
    @(negedge clk);
    ifa.OPB_WE = 1'b0;
    ifb.OPB_WE = 1'b0;
  endtask

  task automatic opb_rd(input bit b, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    if (b) begin ifb.OPB_ADDR = a; ifb.OPB_RE = 1'b1; end
    else   begin ifa.OPB_ADDR = a; ifa.OPB_RE = 1'b1; end
    #1;
    d = b ? ifb.OPB_DO : ifa.OPB_DO;
    ifa.OPB_RE = 1'b0;
    ifb.OPB_RE = 1'b0;
  endtask

  task automatic wait_xfers(input int base, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((log_a.size() >= base + n) && !busy_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_trig(input bit b, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((b ? trig_b : trig_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({trig_a, data_a, addr_a, busy_a, err_a} !== 14'd0) begin errors++; $display("FAIL reset_out_a got %h exp 0", {trig_a, data_a, addr_a, busy_a, err_a}); end
    checks++; if ({trig_b, data_b, addr_b, busy_b, err_b} !== 14'd0) begin errors++; $display("FAIL reset_out_b got %h exp 0", {trig_b, data_b, addr_b, busy_b, err_b}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
    opb_rd(0, 4'h8, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
    opb_rd(0, 4'h3, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_shadow3 got %h exp 0", rd); end
    opb_rd(0, 4'hA, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_tmo_cnt got %h exp 0", rd); end
  endtask

  task automatic test_single;
    logic [31:0] rd;
    bit ok;
    int base;
    base = log_a.size();
    opb_wr(0, 4'h3, 16'h005A);
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'h0000_0800) begin errors++; $display("FAIL single_dirty_pre got %h exp 00000800", rd); end
    opb_rd(0, 4'h3, rd);
    checks++; if (rd !== 32'h0000_005A) begin errors++; $display("FAIL single_shadow got %h exp 5a", rd); end
    opb_wr(0, 4'h8, 16'h0001);
    wait_xfers(base, 1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got timeout exp transfer"); end
    repeat (50) @(negedge clk);
    checks++; if (log_a.size() !== base + 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", log_a.size() - base); end
    checks++; if (log_a[base] !== {3'd3, 8'h5A}) begin errors++; $display("FAIL single_xfer got %h exp %h", log_a[base], {3'd3, 8'h5A}); end
    checks++; if ({addr_a, data_a, busy_a} !== {3'd3, 8'h5A, 1'b0}) begin errors++; $display("FAIL single_hold got %h exp %h", {addr_a, data_a, busy_a}, {3'd3, 8'h5A, 1'b0}); end
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'h0003_0000) begin errors++; $display("FAIL single_status got %h exp 00030000", rd); end
  endtask

  task automatic test_order;
    logic [31:0] rd;
    bit ok;
    int base;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    base = log_a.size();
    opb_wr(0, 4'h0, 16'h0010);
    opb_wr(0, 4'h7, 16'h0070);
    opb_wr(0, 4'h2, 16'h0020);
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'h0000_8500) begin errors++; $display("FAIL order_dirty got %h exp 00008500", rd); end
    opb_wr(0, 4'h8, 16'h0001);
    wait_xfers(base, 3, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL order_done got timeout exp 3 transfers"); end
    checks++; if (log_a[base] !== {3'd0, 8'h10}) begin errors++; $display("FAIL order_first got %h exp %h", log_a[base], {3'd0, 8'h10}); end
    checks++; if (log_a[base+1] !== {3'd2, 8'h20}) begin errors++; $display("FAIL order_second got %h exp %h", log_a[base+1], {3'd2, 8'h20}); end
    checks++; if (log_a[base+2] !== {3'd7, 8'h70}) begin errors++; $display("FAIL order_third got %h exp %h", log_a[base+2], {3'd7, 8'h70}); end
    // Pointer must have wrapped to 0: with ch1 and ch7 dirty, ch1 goes first
    opb_wr(0, 4'h8, 16'h0000);
    opb_wr(0, 4'h7, 16'h0071);
    opb_wr(0, 4'h1, 16'h0011);
    base = log_a.size();
    opb_wr(0, 4'h8, 16'h0001);
    wait_xfers(base, 2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done got timeout exp 2 transfers"); end
    checks++; if (log_a[base] !== {3'd1, 8'h11}) begin errors++; $display("FAIL wrap_first got %h exp %h", log_a[base], {3'd1, 8'h11}); end
    checks++; if (log_a[base+1] !== {3'd7, 8'h71}) begin errors++; $display("FAIL wrap_second got %h exp %h", log_a[base+1], {3'd7, 8'h71}); end
  endtask

  task automatic test_rewrite;
    logic [31:0] rd;
    bit ok;
    int base;
    base = log_a.size();
    opb_wr(0, 4'h5, 16'h0011);
    wait_trig(0, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_trig got no trig exp trig"); end
    opb_wr(0, 4'h5, 16'h0022);
    wait_xfers(base, 2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rewrite_done got timeout exp 2 transfers"); end
    checks++; if (log_a[base] !== {3'd5, 8'h11}) begin errors++; $display("FAIL rewrite_first got %h exp %h", log_a[base], {3'd5, 8'h11}); end
    checks++; if (log_a[base+1] !== {3'd5, 8'h22}) begin errors++; $display("FAIL rewrite_second got %h exp %h", log_a[base+1], {3'd5, 8'h22}); end
    repeat (20) @(negedge clk);
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'h0005_0000) begin errors++; $display("FAIL rewrite_status got %h exp 00050000", rd); end
  endtask

  task automatic test_update_all;
    logic [31:0] rd;
    bit ok;
    int base;
    base = log_a.size();
    opb_wr(0, 4'h8, 16'h0003);
    opb_rd(0, 4'h8, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL upd_ctrl_read got %h exp 1", rd); end
    wait_xfers(base, 8, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL upd_done got timeout exp 8 transfers"); end
    checks++; if (log_a.size() !== base + 8) begin errors++; $display("FAIL upd_count got %0d exp 8", log_a.size() - base); end
    checks++; if (log_a[base] !== {3'd6, 8'h00}) begin errors++; $display("FAIL upd_first got %h exp %h", log_a[base], {3'd6, 8'h00}); end
    checks++; if (log_a[base+1] !== {3'd7, 8'h71}) begin errors++; $display("FAIL upd_second got %h exp %h", log_a[base+1], {3'd7, 8'h71}); end
    checks++; if (log_a[base+2] !== {3'd0, 8'h10}) begin errors++; $display("FAIL upd_third got %h exp %h", log_a[base+2], {3'd0, 8'h10}); end
    checks++; if (log_a[base+7] !== {3'd5, 8'h22}) begin errors++; $display("FAIL upd_last got %h exp %h", log_a[base+7], {3'd5, 8'h22}); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    bit ok;
    opb_wr(1, 4'h6, 16'h0066);
    opb_wr(1, 4'h8, 16'h0001);
    wait_trig(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_trig got no trig exp trig"); end
    // Disable mid-transfer so the aborted channel is not retried
    opb_wr(1, 4'h8, 16'h0000);
    for (int i = 0; i < 60 && trig_b === 1'b1; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    checks++; if (hi_b !== 16) begin errors++; $display("FAIL tmo_trig_len got %0d exp 16", hi_b); end
    checks++; if (rise_b !== 1) begin errors++; $display("FAIL tmo_pulses got %0d exp 1", rise_b); end
    checks++; if ({trig_b, addr_b, data_b, busy_b, err_b} !== {1'b0, 3'd6, 8'h66, 1'b0, 1'b1}) begin errors++; $display("FAIL tmo_pins got %h exp %h", {trig_b, addr_b, data_b, busy_b, err_b}, {1'b0, 3'd6, 8'h66, 1'b0, 1'b1}); end
    opb_rd(1, 4'h9, rd);
    checks++; if (rd !== 32'h0006_4002) begin errors++; $display("FAIL tmo_status got %h exp 00064002", rd); end
    opb_rd(1, 4'hA, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL tmo_count got %h exp 1", rd); end
    opb_wr(1, 4'h9, 16'h0002);
    opb_rd(1, 4'h9, rd);
    checks++; if (rd !== 32'h0006_4000) begin errors++; $display("FAIL tmo_err_clear got %h exp 00064000", rd); end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL tmo_err_pin got %b exp 0", err_b); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bit ok;
    int base;
    base = log_a.size();
    opb_wr(0, 4'h1, 16'h0033);
    wait_trig(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_trig got no trig exp trig"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({trig_a, addr_a, data_a, busy_a} !== 13'd0) begin errors++; $display("FAIL rstmid_pins got %h exp 0", {trig_a, addr_a, data_a, busy_a}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    opb_rd(0, 4'h8, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_ctrl got %h exp 0", rd); end
    opb_rd(0, 4'h1, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_shadow got %h exp 0", rd); end
    opb_rd(0, 4'h9, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_status got %h exp 0", rd); end
    repeat (200) @(negedge clk);
    checks++; if (log_a.size() !== base + 1) begin errors++; $display("FAIL rstmid_no_xfer got %0d exp 1", log_a.size() - base); end
  endtask

  task automatic test_refresh;
    int base;
`ifdef ILIM_DAC_AUTO_REFRESH_EN
    bit ok;
`endif
    base = log_a.size();
    opb_wr(0, 4'h8, 16'h0001);
`ifdef ILIM_DAC_AUTO_REFRESH_EN
    wait_xfers(base, 8, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL refresh_done got timeout exp 8 transfers"); end
    checks++; if (log_a[base] !== {3'd0, 8'h00}) begin errors++; $display("FAIL refresh_first got %h exp 000", log_a[base]); end
    checks++; if (log_a[base+7] !== {3'd7, 8'h00}) begin errors++; $display("FAIL refresh_last got %h exp %h", log_a[base+7], {3'd7, 8'h00}); end
`else
    repeat (1300) @(negedge clk);
    checks++; if (log_a.size() !== base) begin errors++; $display("FAIL refresh_none got %0d exp 0", log_a.size() - base); end
`endif
  endtask

  initial begin
    ifa.OPB_ADDR = 4'h0; ifa.OPB_DI = 16'h0; ifa.OPB_WE = 1'b0; ifa.OPB_RE = 1'b0;
    ifb.OPB_ADDR = 4'h0; ifb.OPB_DI = 16'h0; ifb.OPB_WE = 1'b0; ifb.OPB_RE = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_order();
    test_rewrite();
    test_update_all();
    test_timeout();
    test_reset_mid();
    test_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
